// File: rtl/ps2_direction_decoder.sv
// ps2_direction_decoder
// PS/2 device-to-host receiver with key-state tracking for the movement keys
// (W/A/S/D) and the fire key (Space). Produces a one-hot direction code
// (0001 up, 0010 down, 0100 left, 1000 right) and a boom flag.
// Optional build macro: PS2_ARROW_EN -- when defined, E0-prefixed arrow-key
// codes also drive the direction flags.
module ps2_direction_decoder #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] direction,
    output logic       boom,
    output logic       key_valid,
    output logic [7:0] scan_code,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    // True when data bits plus the parity bit contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

    logic [SYNC_STAGES-1:0] clk_sync_r;
    logic [SYNC_STAGES-1:0] data_sync_r;
    logic                   clk_prev_r;
    logic                   fall_s;
    logic                   data_s;

    rx_state_t              state_r;
    logic [2:0]             bit_cnt_r;
    logic [7:0]             shift_r;
    logic                   parity_r;
    logic [CNT_W-1:0]       to_cnt_r;

    logic                   accept_s;
    logic                   err_s;
    logic                   timeout_s;

    logic [3:0]             held_r;
    logic [1:0]             last_r;
    logic                   fire_r;
    logic                   brk_r;
    logic                   ext_r;

    logic [3:0]             held_nxt_s;
    logic [1:0]             last_nxt_s;
    logic                   fire_nxt_s;
    logic                   brk_nxt_s;
    logic                   ext_nxt_s;
    logic                   hit_dir_s;
    logic                   hit_fire_s;
    logic [1:0]             key_idx_s;
    logic [3:0]             dir_nxt_s;

    // Synchronise the asynchronous PS/2 lines; idle level of both is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_r  <= {SYNC_STAGES{1'b1}};
            data_sync_r <= {SYNC_STAGES{1'b1}};
            clk_prev_r  <= 1'b1;
        end else begin
            clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
            data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ps2_data};
            clk_prev_r  <= clk_sync_r[SYNC_STAGES-1];
        end
    end

    assign fall_s    = clk_prev_r & ~clk_sync_r[SYNC_STAGES-1];
    assign data_s    = data_sync_r[SYNC_STAGES-1];
    assign timeout_s = (state_r != ST_IDLE) && !fall_s && (to_cnt_r == TO_LAST);
    assign accept_s  = fall_s && (state_r == ST_STOP) && data_s
                       && odd_parity_ok(shift_r, parity_r);
    assign err_s     = (fall_s && (state_r == ST_STOP) && !accept_s) || timeout_s;

    // Frame receiver: one transition per falling PS/2 clock edge, with an
    // inactivity timeout that abandons any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            parity_r  <= 1'b0;
            to_cnt_r  <= '0;
        end else if (timeout_s) begin
            state_r  <= ST_IDLE;
            to_cnt_r <= '0;
        end else begin
            if (state_r == ST_IDLE || fall_s) begin
                to_cnt_r <= '0;
            end else begin
                to_cnt_r <= to_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (fall_s) begin
                case (state_r)
                    ST_IDLE: begin
                        if (!data_s) begin
                            state_r   <= ST_DATA;
                            bit_cnt_r <= 3'd0;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_DATA: begin
                        shift_r   <= {data_s, shift_r[7:1]};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= ST_PARITY;
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end
                    ST_PARITY: begin
                        parity_r <= data_s;
                        state_r  <= ST_STOP;
                    end
                    ST_STOP: begin
                        state_r <= ST_IDLE;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

    // Decode the accepted byte into next held-key, prefix and direction state.
    always_comb begin
        held_nxt_s = held_r;
        last_nxt_s = last_r;
        fire_nxt_s = fire_r;
        brk_nxt_s  = brk_r;
        ext_nxt_s  = ext_r;
        hit_dir_s  = 1'b0;
        hit_fire_s = 1'b0;
        key_idx_s  = 2'd0;
        dir_nxt_s  = 4'b0000;

        if (!ext_r) begin
            case (shift_r)
                8'h1D:   begin hit_dir_s = 1'b1; key_idx_s = 2'd0; end
                8'h1B:   begin hit_dir_s = 1'b1; key_idx_s = 2'd1; end
                8'h1C:   begin hit_dir_s = 1'b1; key_idx_s = 2'd2; end
                8'h23:   begin hit_dir_s = 1'b1; key_idx_s = 2'd3; end
                8'h29:   begin hit_fire_s = 1'b1; end
                default: begin hit_dir_s = 1'b0; end
            endcase
        end else begin
`ifdef PS2_ARROW_EN
            case (shift_r)
                8'h75:   begin hit_dir_s = 1'b1; key_idx_s = 2'd0; end
                8'h72:   begin hit_dir_s = 1'b1; key_idx_s = 2'd1; end
                8'h6B:   begin hit_dir_s = 1'b1; key_idx_s = 2'd2; end
                8'h74:   begin hit_dir_s = 1'b1; key_idx_s = 2'd3; end
                default: begin hit_dir_s = 1'b0; end
            endcase
`else
            hit_dir_s = 1'b0;
`endif
        end

        if (accept_s) begin
            if (shift_r == 8'hF0) begin
                brk_nxt_s = 1'b1;
            end else if (shift_r == 8'hE0) begin
                ext_nxt_s = 1'b1;
            end else begin
                if (hit_dir_s) begin
                    held_nxt_s[key_idx_s] = ~brk_r;
                    // A repeat make of an already-held key leaves arbitration alone.
                    if (!brk_r && !held_r[key_idx_s]) begin
                        last_nxt_s = key_idx_s;
                    end else begin
                        last_nxt_s = last_r;
                    end
                end else if (hit_fire_s) begin
                    fire_nxt_s = ~brk_r;
                end else begin
                    held_nxt_s = held_r;
                end
                brk_nxt_s = 1'b0;
                ext_nxt_s = 1'b0;
            end
        end else if (err_s) begin
            brk_nxt_s = 1'b0;
            ext_nxt_s = 1'b0;
        end else begin
            held_nxt_s = held_r;
        end

        if (held_nxt_s[last_nxt_s]) begin
            dir_nxt_s = 4'b0001 << last_nxt_s;
        end else if (held_nxt_s[0]) begin
            dir_nxt_s = 4'b0001;
        end else if (held_nxt_s[1]) begin
            dir_nxt_s = 4'b0010;
        end else if (held_nxt_s[2]) begin
            dir_nxt_s = 4'b0100;
        end else if (held_nxt_s[3]) begin
            dir_nxt_s = 4'b1000;
        end else begin
            dir_nxt_s = 4'b0000;
        end
    end

    // Register key state and all outputs; pulses last exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            held_r    <= 4'b0000;
            last_r    <= 2'd0;
            fire_r    <= 1'b0;
            brk_r     <= 1'b0;
            ext_r     <= 1'b0;
            direction <= 4'b0000;
            boom      <= 1'b0;
            key_valid <= 1'b0;
            scan_code <= 8'h00;
            frame_err <= 1'b0;
        end else begin
            held_r    <= held_nxt_s;
            last_r    <= last_nxt_s;
            fire_r    <= fire_nxt_s;
            brk_r     <= brk_nxt_s;
            ext_r     <= ext_nxt_s;
            direction <= dir_nxt_s;
            boom      <= fire_nxt_s;
            key_valid <= accept_s;
            frame_err <= err_s;
            if (accept_s) begin
                scan_code <= shift_r;
            end else begin
                scan_code <= scan_code;
            end
        end
    end

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Scoreboard bench for ps2_direction_decoder: stimulus pushes the expected
// response for every frame, an independent monitor pops and compares each
// key_valid / frame_err pulse together with direction and boom.
module tb_ps2_direction_decoder;

    localparam int TO_CYC = 400;
    localparam int HALF   = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [3:0] direction;
    logic       boom;
    logic       key_valid;
    logic [7:0] scan_code;
    logic       frame_err;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        logic [3:0] dir;
        logic       boom;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    ps2_direction_decoder #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .direction (direction),
        .boom      (boom),
        .key_valid (key_valid),
        .scan_code (scan_code),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every output pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (!rst && (key_valid || frame_err)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: key_valid=%b frame_err=%b scan=%h", key_valid, frame_err, scan_code);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("frame_err", {7'd0, frame_err}, {7'd0, e.is_err});
                check("key_valid", {7'd0, key_valid}, {7'd0, ~e.is_err});
                if (!e.is_err) check("scan_code", scan_code, e.code);
                check("direction", {4'd0, direction}, {4'd0, e.dir});
                check("boom", {7'd0, boom}, {7'd0, e.boom});
            end
        end
    end

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input bit bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        repeat (30) @(negedge clk);
    endtask

    task automatic push(input bit is_err, input logic [7:0] code, input logic [3:0] dir, input logic bm);
        exp_t e;
        e.is_err = is_err;
        e.code   = code;
        e.dir    = dir;
        e.boom   = bm;
        exp_q.push_back(e);
    endtask

    task automatic key(input logic [7:0] b, input logic [3:0] dir, input logic bm);
        push(1'b0, b, dir, bm);
        send(b, 1'b0);
    endtask

    initial begin
        logic [3:0] arrow_dir;
`ifdef PS2_ARROW_EN
        arrow_dir = 4'b0100;
`else
        arrow_dir = 4'b0000;
`endif
        repeat (5) @(negedge clk);
        check("rst_direction", {4'd0, direction}, 8'h00);
        check("rst_boom", {7'd0, boom}, 8'h00);
        check("rst_key_valid", {7'd0, key_valid}, 8'h00);
        check("rst_scan_code", scan_code, 8'h00);
        check("rst_frame_err", {7'd0, frame_err}, 8'h00);
        rst = 1'b0;
        repeat (1000) @(negedge clk);
        check("idle_direction", {4'd0, direction}, 8'h00);

        // W press and release
        key(8'h1D, 4'b0001, 1'b0);
        key(8'hF0, 4'b0001, 1'b0);
        key(8'h1D, 4'b0000, 1'b0);

        // A, D, release D, then W over A and fixed-priority fallback
        key(8'h1C, 4'b0100, 1'b0);
        key(8'h23, 4'b1000, 1'b0);
        key(8'h1C, 4'b1000, 1'b0);   // typematic repeat of A: no change
        key(8'hF0, 4'b1000, 1'b0);
        key(8'h23, 4'b0100, 1'b0);
        key(8'h1D, 4'b0001, 1'b0);
        key(8'hF0, 4'b0001, 1'b0);
        key(8'h1D, 4'b0100, 1'b0);
        key(8'hF0, 4'b0100, 1'b0);
        key(8'h1C, 4'b0000, 1'b0);

        // Fire key: bad parity rejected, then good press and release
        push(1'b1, 8'h00, 4'b0000, 1'b0);
        send(8'h29, 1'b1);
        key(8'h29, 4'b0000, 1'b1);
        key(8'hF0, 4'b0000, 1'b1);
        key(8'h29, 4'b0000, 1'b0);

        // Partial frame abandoned by timeout, then a clean S frame
        push(1'b1, 8'h00, 4'b0000, 1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        repeat (TO_CYC + 100) @(negedge clk);
        key(8'h1B, 4'b0010, 1'b0);

        // Frame error clears the pending break prefix
        key(8'hF0, 4'b0010, 1'b0);
        push(1'b1, 8'h00, 4'b0010, 1'b0);
        send(8'h1B, 1'b1);
        key(8'h1B, 4'b0010, 1'b0);
        key(8'hF0, 4'b0010, 1'b0);
        key(8'h1B, 4'b0000, 1'b0);

        // Extended codes: arrow left and its break; extended W always ignored
        key(8'hE0, 4'b0000, 1'b0);
        key(8'h6B, arrow_dir, 1'b0);
        key(8'hE0, arrow_dir, 1'b0);
        key(8'hF0, arrow_dir, 1'b0);
        key(8'h6B, 4'b0000, 1'b0);
        key(8'hE0, 4'b0000, 1'b0);
        key(8'h1D, 4'b0000, 1'b0);

        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_pulses: %0d outstanding expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_direction_decoder.md
Name: ps2_direction_decoder

Overview:
- PS/2 keyboard receiver and key-state decoder that produces the `direction` and `boom` inputs of the player-plane position/collision block.
- Deserialises PS/2 device-to-host frames and tracks make/break codes for the movement and fire keys.
- Presents a strictly one-hot (or zero) 4-bit direction code matching the plane block's case decode: 0001 up, 0010 down, 0100 left, 1000 right.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the ps2_clk/ps2_data synchronisers (min 2).
- TIMEOUT_CYCLES, 100000, clk cycles with no ps2_clk falling edge before a partial frame is abandoned.

Ports:
- clk  in  1  system clock; everything is synchronous to it.
- rst  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock from the keyboard; asynchronous.
- ps2_data  in  1  raw PS/2 data from the keyboard; asynchronous.
- direction  out  4  one-hot movement code; 4'b0000 when no direction key is held.
- boom  out  1  high while the fire key is held.
- key_valid  out  1  one-cycle pulse for each accepted byte.
- scan_code  out  8  last accepted byte; valid when key_valid is high.
- frame_err  out  1  one-cycle pulse on a parity, stop-bit or timeout error.

Behaviour:
- Reset values: direction=0, boom=0, key_valid=0, scan_code=8'h00, frame_err=0. Reset also clears held-key flags, brk/ext prefix flags, the receive FSM (→IDLE) and the timeout counter. Reset mid-frame discards the partial frame.
- Sampling: both inputs pass through SYNC_STAGES flops. A falling edge is a synchronised ps2_clk 1→0 transition seen between consecutive clk cycles. ps2_data is sampled on that edge.
- Receive FSM: IDLE→DATA→PARITY→STOP→IDLE, one transition per falling edge.
  - IDLE: sampled data 0 is the start bit → DATA with bit count 0. Sampled data 1 stays in IDLE, no error.
  - DATA: shift bits in LSB first. After 8 bits → PARITY.
  - PARITY: store the parity bit → STOP.
  - STOP: accept the byte if the stop bit is 1 and the parity over data+parity is odd; otherwise pulse frame_err. Return to IDLE in both cases.
- Timeout: outside IDLE, a counter increments every clk and clears on each falling edge. Reaching TIMEOUT_CYCLES forces IDLE and pulses frame_err.
- Accept timing: key_valid and scan_code are registered on the cycle after the STOP-edge cycle. direction and boom update on that same cycle.
- Key decode on each accepted byte:
  - 8'hF0 sets brk. 8'hE0 sets ext. Neither changes key state.
  - Any other byte is a key code. brk=1 means release, otherwise press. Both brk and ext clear after the key code.
  - Non-extended codes: W 8'h1D up, S 8'h1B down, A 8'h1C left, D 8'h23 right, Space 8'h29 fire.
  - Extended codes (ext=1): see the optional feature.
  - Unknown codes are ignored.
- Error handling: a frame_err also clears brk and ext. Held-key state is kept.
- Typematic repeat: repeated make codes of an already-held key are idempotent.
- Direction arbitration:
  - Keep 4 held flags plus a 2-bit last-pressed index.
  - direction shows the last-pressed direction while it is held.
  - When that key is released, fall back to fixed priority among still-held keys: up > down > left > right.
  - If none are held, direction = 0.
  - direction is never multi-hot.
- boom equals the fire held flag.
- A byte accepted on the same cycle as a timeout cannot occur, because STOP acceptance returns the FSM to IDLE first.

Optional Feature:
- Macro: PS2_ARROW_EN.
- Defined: extended codes decode as arrow keys: E0 75 up, E0 72 down, E0 6B left, E0 74 right, each with make and break (E0 F0 xx) handling. Extended codes for W/A/S/D values are ignored.
- Undefined: any key code that follows E0 is ignored, even if its value matches a letter key. key_valid still pulses for every accepted byte.

Test Plan:
- Reset, then idle inputs for 1000 cycles -> direction=0, boom=0, no key_valid, no frame_err.
- Send 1D, then F0 1D -> key_valid pulses ×3 with scan_code 1D, F0, 1D. direction=0001 after the first byte, 0000 after the last.
- Press A (1C), press D (23), release D (F0 23) -> direction 0100, then 1000, then 0100.
- Send 29 with a wrong parity bit -> one frame_err pulse, no key_valid, boom stays 0. Then a good 29 -> boom=1.
- Send start bit plus 3 data bits, then stall TIMEOUT_CYCLES -> frame_err pulse, FSM in IDLE. The next full frame 1B decodes → direction=0010.
- With PS2_ARROW_EN: E0 6B -> direction=0100; E0 F0 6B -> 0000. Without the macro: same stimulus -> direction stays 0000, key_valid pulses for E0 and 6B.
